// File: rtl/mover_pkg.sv
// Shared definitions for the multi-object movement engine: sweep FSM states
// and the bit positions inside each object's 4-bit border edge code.
package mover_pkg;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_UPDATE = 1'b1
  } state_t;

  localparam int EDGE_LEFT   = 3;
  localparam int EDGE_TOP    = 2;
  localparam int EDGE_RIGHT  = 1;
  localparam int EDGE_BOTTOM = 0;

endpackage

// File: rtl/mover_velocity.sv
// Per-object velocity register pair (vx, vy).
// A border hit forces the sign away from the wall it touched; a switch pulse
// negates one axis unless a border hit is reported on that same axis.
// Optional build macro MOVER_SPEEDUP_EN: each border-induced sign change also
// grows the magnitude by SPEED_STEP, saturating at MAX_SPEED.
module mover_velocity
  import mover_pkg::*;
#(
  parameter int SPEED_W = 8,
  parameter int X_SPEED = 24,
  parameter int Y_SPEED = 24
`ifdef MOVER_SPEEDUP_EN
  ,
  parameter int SPEED_STEP = 8,
  parameter int MAX_SPEED  = 96
`endif
) (
  input  logic                      clk,
  input  logic                      resetN,
  input  logic                      border_collision,
  input  logic [3:0]                hit_edge,
  input  logic                      switch_pulse,
  input  logic                      random_axis,
  output logic signed [SPEED_W-1:0] vx,
  output logic signed [SPEED_W-1:0] vy
);

  logic [SPEED_W-1:0]        x_abs, y_abs;
  logic                      hit_x, hit_y;
  logic signed [SPEED_W-1:0] vx_next, vy_next;

  // Magnitude applied after a bounce
  function automatic logic [SPEED_W-1:0] bounce_mag(input logic [SPEED_W-1:0] mag);
`ifdef MOVER_SPEEDUP_EN
    logic [SPEED_W:0] grown;
    grown = {1'b0, mag} + (SPEED_W+1)'(SPEED_STEP);
    if (grown > (SPEED_W+1)'(MAX_SPEED))
      return SPEED_W'(MAX_SPEED);
    return grown[SPEED_W-1:0];
`else
    return mag;
`endif
  endfunction

  // Next-velocity rules: border sign forcing has priority over a same-axis switch
  always_comb begin
    x_abs   = vx[SPEED_W-1] ? -vx : vx;
    y_abs   = vy[SPEED_W-1] ? -vy : vy;
    hit_x   = border_collision && (hit_edge[EDGE_LEFT] || hit_edge[EDGE_RIGHT]);
    hit_y   = border_collision && (hit_edge[EDGE_TOP]  || hit_edge[EDGE_BOTTOM]);
    vx_next = vx;
    vy_next = vy;

    if (border_collision && hit_edge[EDGE_LEFT] && vx[SPEED_W-1])
      vx_next = $signed(bounce_mag(x_abs));
    else if (border_collision && hit_edge[EDGE_RIGHT] && !vx[SPEED_W-1] && (vx != '0))
      vx_next = -$signed(bounce_mag(x_abs));
    else if (switch_pulse && !random_axis && !hit_x)
      vx_next = -vx;

    if (border_collision && hit_edge[EDGE_TOP] && vy[SPEED_W-1])
      vy_next = $signed(bounce_mag(y_abs));
    else if (border_collision && hit_edge[EDGE_BOTTOM] && !vy[SPEED_W-1] && (vy != '0))
      vy_next = -$signed(bounce_mag(y_abs));
    else if (switch_pulse && random_axis && !hit_y)
      vy_next = -vy;
  end

  // Velocity registers, updated every cycle regardless of the sweep state
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      vx <= SPEED_W'(X_SPEED);
      vy <= SPEED_W'(Y_SPEED);
    end else begin
      vx <= vx_next;
      vy <= vy_next;
    end
  end

endmodule

// File: rtl/multi_object_move.sv
// Time-multiplexed movement engine: one shared X/Y adder pair advances one
// object per clock after each frame pulse; pixel outputs are the fixed-point
// positions floor-shifted by FRAC_BITS.
// Optional build macro MOVER_SPEEDUP_EN enables bounce speed-up in
// mover_velocity.
module multi_object_move
  import mover_pkg::*;
#(
  parameter int NUM_OBJ     = 4,
  parameter int PIXEL_WIDTH = 11,
  parameter int FRAC_BITS   = 6,
  parameter int SPEED_W     = 8,
  parameter int X_SPEED     = 24,
  parameter int Y_SPEED     = 24,
  parameter int INIT_X      = 100,
  parameter int INIT_Y      = 200,
  parameter int X_SPACING   = 64,
  parameter int SPEED_STEP  = 8,
  parameter int MAX_SPEED   = 96
) (
  input  logic                           clk,
  input  logic                           resetN,
  input  logic                           startOfFrame,
  input  logic [NUM_OBJ-1:0]             border_collision,
  input  logic [4*NUM_OBJ-1:0]           HitEdgeCode,
  input  logic [NUM_OBJ-1:0]             switch_direction_pulse,
  input  logic [NUM_OBJ-1:0]             random_axis,
  output logic [PIXEL_WIDTH*NUM_OBJ-1:0] topLeftX,
  output logic [PIXEL_WIDTH*NUM_OBJ-1:0] topLeftY,
  output logic                           busy,
  output logic                           frame_done,
  output logic                           overrun
);

  localparam int POS_W = PIXEL_WIDTH + FRAC_BITS;
  localparam int IDX_W = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1;

  state_t                    state;
  logic [IDX_W-1:0]          idx;
  logic                      last_slot;
  logic signed [POS_W-1:0]   pos_x [NUM_OBJ];
  logic signed [POS_W-1:0]   pos_y [NUM_OBJ];
  logic signed [SPEED_W-1:0] vx    [NUM_OBJ];
  logic signed [SPEED_W-1:0] vy    [NUM_OBJ];
  logic signed [POS_W-1:0]   sum_x, sum_y;

  function automatic logic signed [POS_W-1:0] sext(input logic signed [SPEED_W-1:0] v);
    return {{(POS_W-SPEED_W){v[SPEED_W-1]}}, v};
  endfunction

  function automatic logic signed [POS_W-1:0] init_x(input int i);
    return POS_W'((INIT_X + i * X_SPACING) << FRAC_BITS);
  endfunction

  function automatic logic signed [POS_W-1:0] init_y();
    return POS_W'(INIT_Y << FRAC_BITS);
  endfunction

  for (genvar g = 0; g < NUM_OBJ; g++) begin : g_obj
    mover_velocity #(
      .SPEED_W    (SPEED_W),
      .X_SPEED    (X_SPEED),
      .Y_SPEED    (Y_SPEED)
`ifdef MOVER_SPEEDUP_EN
      ,
      .SPEED_STEP (SPEED_STEP),
      .MAX_SPEED  (MAX_SPEED)
`endif
    ) u_vel (
      .clk              (clk),
      .resetN           (resetN),
      .border_collision (border_collision[g]),
      .hit_edge         (HitEdgeCode[4*g +: 4]),
      .switch_pulse     (switch_direction_pulse[g]),
      .random_axis      (random_axis[g]),
      .vx               (vx[g]),
      .vy               (vy[g])
    );

    assign topLeftX[PIXEL_WIDTH*g +: PIXEL_WIDTH] = PIXEL_WIDTH'(pos_x[g] >>> FRAC_BITS);
    assign topLeftY[PIXEL_WIDTH*g +: PIXEL_WIDTH] = PIXEL_WIDTH'(pos_y[g] >>> FRAC_BITS);
  end

  assign last_slot = (idx == IDX_W'(NUM_OBJ - 1));
  assign busy      = (state == ST_UPDATE);

  // Shared adder pair serving the object selected by idx
  always_comb begin
    sum_x = pos_x[idx] + sext(vx[idx]);
    sum_y = pos_y[idx] + sext(vy[idx]);
  end

  // Sweep FSM: one object slot per clock, frame pulses during a sweep are dropped
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state      <= ST_IDLE;
      idx        <= '0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (startOfFrame) begin
            state <= ST_UPDATE;
            idx   <= '0;
          end
        end
        ST_UPDATE: begin
          if (startOfFrame)
            overrun <= 1'b1;
          if (last_slot) begin
            state      <= ST_IDLE;
            idx        <= '0;
            frame_done <= 1'b1;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          idx   <= '0;
        end
      endcase
    end
  end

  // Position array: the selected object takes the adder result during a sweep
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      for (int i = 0; i < NUM_OBJ; i++) begin
        pos_x[i] <= init_x(i);
        pos_y[i] <= init_y();
      end
    end else if (state == ST_UPDATE) begin
      pos_x[idx] <= sum_x;
      pos_y[idx] <= sum_y;
    end
  end

endmodule

// File: tb/tb_multi_object_move.sv
// Scoreboard bench for multi_object_move: stimulus pushes expected pixel
// positions per frame; a monitor pops them on every frame_done pulse.
module tb_multi_object_move;

  localparam int N     = 4;
  localparam int PW    = 11;
  localparam int FB    = 6;
  localparam int POS_W = PW + FB;

  logic              clk = 1'b0;
  logic              resetN;
  logic              startOfFrame;
  logic [N-1:0]      border_collision;
  logic [4*N-1:0]    HitEdgeCode;
  logic [N-1:0]      switch_direction_pulse;
  logic [N-1:0]      random_axis;
  logic [PW*N-1:0]   topLeftX, topLeftY;
  logic              busy, frame_done, overrun;

  always #5 clk = ~clk;

  multi_object_move dut (
    .clk                    (clk),
    .resetN                 (resetN),
    .startOfFrame           (startOfFrame),
    .border_collision       (border_collision),
    .HitEdgeCode            (HitEdgeCode),
    .switch_direction_pulse (switch_direction_pulse),
    .random_axis            (random_axis),
    .topLeftX               (topLeftX),
    .topLeftY               (topLeftY),
    .busy                   (busy),
    .frame_done             (frame_done),
    .overrun                (overrun)
  );

  int total = 0;
  int bad   = 0;
  int done_cnt = 0;
  int exp_q[$];
  int m_px[N], m_py[N], m_vx[N], m_vy[N];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int pix(input int p);
    logic signed [POS_W-1:0] t;
    t = p[POS_W-1:0];
    t = t >>> FB;
    return int'(t);
  endfunction

  function automatic int out_x(input int i);
    logic signed [PW-1:0] v;
    v = topLeftX[i*PW +: PW];
    return int'(v);
  endfunction

  function automatic int out_y(input int i);
    logic signed [PW-1:0] v;
    v = topLeftY[i*PW +: PW];
    return int'(v);
  endfunction

  function automatic int bounce(input int m);
`ifdef MOVER_SPEEDUP_EN
    return (m + 8 > 96) ? 96 : m + 8;
`else
    return m;
`endif
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_px[i] = (100 + 64 * i) * 64;
      m_py[i] = 200 * 64;
      m_vx[i] = 24;
      m_vy[i] = 24;
    end
  endtask

  // Velocity rules for one object: sign forced away from a wall, switch negates
  task automatic model_event(input int o, input bit bc, input bit [3:0] e,
                             input bit sw, input bit ax);
    bit on_x, on_y;
    on_x = bc && (e[3] || e[1]);
    on_y = bc && (e[2] || e[0]);
    if (bc && e[3] && m_vx[o] < 0)      m_vx[o] = bounce(-m_vx[o]);
    else if (bc && e[1] && m_vx[o] > 0) m_vx[o] = -bounce(m_vx[o]);
    else if (sw && !ax && !on_x)        m_vx[o] = -m_vx[o];
    if (bc && e[2] && m_vy[o] < 0)      m_vy[o] = bounce(-m_vy[o]);
    else if (bc && e[0] && m_vy[o] > 0) m_vy[o] = -bounce(m_vy[o]);
    else if (sw && ax && !on_y)         m_vy[o] = -m_vy[o];
  endtask

  task automatic model_frame();
    for (int i = 0; i < N; i++) begin
      m_px[i] += m_vx[i];
      m_py[i] += m_vy[i];
    end
    for (int i = 0; i < N; i++) exp_q.push_back(pix(m_px[i]));
    for (int i = 0; i < N; i++) exp_q.push_back(pix(m_py[i]));
  endtask

  task automatic apply_events(input logic [N-1:0] bc, input logic [4*N-1:0] e,
                              input logic [N-1:0] sw, input logic [N-1:0] ax);
    @(negedge clk);
    border_collision       = bc;
    HitEdgeCode            = e;
    switch_direction_pulse = sw;
    random_axis            = ax;
    for (int o = 0; o < N; o++) model_event(o, bc[o], e[4*o +: 4], sw[o], ax[o]);
    @(negedge clk);
    border_collision       = '0;
    HitEdgeCode            = '0;
    switch_direction_pulse = '0;
    random_axis            = '0;
  endtask

  task automatic do_frame(input bit check_busy);
    @(negedge clk);
    startOfFrame = 1'b1;
    model_frame();
    @(negedge clk);
    startOfFrame = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (check_busy) chk($sformatf("busy_slot%0d", k), int'(busy), 1);
      @(negedge clk);
    end
    if (check_busy) begin
      chk("busy_after", int'(busy), 0);
      chk("frame_done_pulse", int'(frame_done), 1);
    end
    @(negedge clk);
    if (check_busy) chk("frame_done_single", int'(frame_done), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int i = 0; i < N; i++) begin
      chk($sformatf("%s_x%0d", tag, i), out_x(i), 100 + 64 * i);
      chk($sformatf("%s_y%0d", tag, i), out_y(i), 200);
    end
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_frame_done"}, int'(frame_done), 0);
    chk({tag, "_overrun"}, int'(overrun), 0);
  endtask

  // Monitor: every frame_done pulse consumes one expected frame
  always @(negedge clk) begin
    if (resetN && frame_done) begin
      done_cnt++;
      if (exp_q.size() < 2 * N) begin
        chk("sb_underflow", exp_q.size(), 2 * N);
      end else begin
        for (int i = 0; i < N; i++) chk($sformatf("sb_x%0d", i), out_x(i), exp_q.pop_front());
        for (int i = 0; i < N; i++) chk($sformatf("sb_y%0d", i), out_y(i), exp_q.pop_front());
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt0;
    logic [N-1:0]   r_bc, r_sw, r_ax, fx, fy;
    logic [4*N-1:0] r_e;

    resetN                 = 1'b0;
    startOfFrame           = 1'b0;
    border_collision       = '0;
    HitEdgeCode            = '0;
    switch_direction_pulse = '0;
    random_axis            = '0;
    model_reset();
    repeat (3) @(negedge clk);
    resetN = 1'b1;
    @(negedge clk);
    check_reset_outputs("rst");

    // Default frames
    do_frame(1);
    for (int i = 0; i < N; i++) chk($sformatf("f1_x%0d", i), out_x(i), 100 + 64 * i);
    do_frame(1);
    do_frame(1);
    chk("f3_x0", out_x(0), 101);
    chk("f3_y0", out_y(0), 201);

    // Object 1 right-edge hit, then the same hit again
    apply_events(4'b0010, 16'h0020, '0, '0);
    do_frame(1);
    chk("hit_x1", out_x(1), 164);
    apply_events(4'b0010, 16'h0020, '0, '0);
    do_frame(0);

    // Object 2: switch on X with right hit in the same cycle, then switch on Y
    apply_events(4'b0100, 16'h0200, 4'b0100, 4'b0000);
    apply_events(4'b0000, 16'h0000, 4'b0100, 4'b0100);
    do_frame(1);

    // Second frame pulse two cycles into the sweep
    cnt0 = done_cnt;
    @(negedge clk); startOfFrame = 1'b1; model_frame();
    @(negedge clk); startOfFrame = 1'b0;
    @(negedge clk); startOfFrame = 1'b1;
    @(negedge clk); startOfFrame = 1'b0;
    for (int k = 0; k < 20 && done_cnt == cnt0; k++) @(negedge clk);
    repeat (4) @(negedge clk);
    chk("overrun_set", int'(overrun), 1);
    chk("overrun_frames", done_cnt - cnt0, 1);

    // Reset two cycles into a sweep
    @(negedge clk); startOfFrame = 1'b1;
    @(negedge clk); startOfFrame = 1'b0;
    @(negedge clk); resetN = 1'b0;
    #1;
    check_reset_outputs("midrst");
    model_reset();
    @(negedge clk); resetN = 1'b1;
    do_frame(1);

    // Randomized events between frames
    for (int it = 0; it < 60; it++) begin
      r_bc = N'($urandom);
      r_e  = (4*N)'($urandom);
      r_sw = N'($urandom);
      r_ax = N'($urandom);
      apply_events(r_bc, r_e, r_sw, r_ax);
      if ($urandom_range(0, 2) != 0) do_frame(0);
    end

    // Drive every object up and left long enough to cross into negative pixels
    fx = '0; fy = '0;
    for (int o = 0; o < N; o++) begin
      fx[o] = (m_vx[o] > 0);
      fy[o] = (m_vy[o] > 0);
    end
    apply_events('0, '0, fx, '0);
    apply_events('0, '0, fy, '1);
    for (int f = 0; f < 800; f++) do_frame(0);

    repeat (4) @(negedge clk);
    chk("sb_leftover", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
